// File: rtl/dvp_tx.sv
// DVP source: serialises RGB565 pixels high byte first onto cmos_pclk/href/vsync/d
// with programmable horizontal and vertical blanking; used as a camera emulator.
module dvp_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int VS_LINES = 2,
    parameter int V_BACK   = 14,
    parameter int V_FRONT  = 10
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cmos_pclk,
    output logic        cmos_href,
    output logic        cmos_vsync,
    output logic [7:0]  cmos_d,
    output logic        frame_start,
    output logic        underflow
);

    localparam int LINE_BYTES  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW = $clog2(LINE_BYTES);
    localparam int VW = $clog2(FRAME_LINES);

    localparam logic [HW-1:0] H_LAST      = HW'(LINE_BYTES - 1);
    localparam logic [HW-1:0] H_ACT_END   = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] V_LAST      = VW'(FRAME_LINES - 1);
    localparam logic [VW-1:0] V_VS_END    = VW'(VS_LINES);
    localparam logic [VW-1:0] V_ACT_START = VW'(VS_LINES + V_BACK);
    localparam logic [VW-1:0] V_ACT_END   = VW'(VS_LINES + V_BACK + V_ACTIVE);

    // Decode of byte (0,0), used when leaving IDLE
    localparam logic START_VSYNC = 1'(VS_LINES > 0);
    localparam logic START_HREF  = 1'((VS_LINES + V_BACK == 0) && (V_ACTIVE > 0) && (H_ACTIVE > 0));

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ph;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [7:0]    pix_lo;

    logic          h_last;
    logic          frame_end;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          nxt_active;
    logic          fetch_next;
    logic [15:0]   fetch_word;

    always_comb begin
        h_last     = (hcnt == H_LAST);
        frame_end  = h_last && (vcnt == V_LAST);
        h_nxt      = h_last ? '0 : hcnt + 1'b1;
        v_nxt      = vcnt;
        if (h_last) begin
            v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
        nxt_active = (v_nxt >= V_ACT_START) && (v_nxt < V_ACT_END) && (h_nxt < H_ACT_END);
        // A frame that is about to stop must not request a pixel for the wrap position
        fetch_next = nxt_active && !h_nxt[0] && !(frame_end && !enable);
        fetch_word = pix_valid ? pix_data : 16'h0000;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (ph && frame_end && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            ph          <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            pix_lo      <= 8'h00;
            pix_ready   <= 1'b0;
            cmos_pclk   <= 1'b0;
            cmos_href   <= 1'b0;
            cmos_vsync  <= 1'b0;
            cmos_d      <= 8'h00;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else if (state == IDLE) begin
            ph          <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            pix_lo      <= 8'h00;
            pix_ready   <= 1'b0;
            cmos_pclk   <= 1'b0;
            cmos_d      <= 8'h00;
            underflow   <= 1'b0;
            frame_start <= enable;
            cmos_vsync  <= enable && START_VSYNC;
            cmos_href   <= enable && START_HREF;
        end else if (!ph) begin
            ph          <= 1'b1;
            cmos_pclk   <= 1'b1;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            pix_ready   <= fetch_next;
        end else if (frame_end && !enable) begin
            ph          <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            pix_lo      <= 8'h00;
            pix_ready   <= 1'b0;
            cmos_pclk   <= 1'b0;
            cmos_href   <= 1'b0;
            cmos_vsync  <= 1'b0;
            cmos_d      <= 8'h00;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // Byte boundary: every output is re-decoded for the next position
            ph          <= 1'b0;
            cmos_pclk   <= 1'b0;
            pix_ready   <= 1'b0;
            hcnt        <= h_nxt;
            vcnt        <= v_nxt;
            frame_start <= frame_end;
            cmos_vsync  <= (v_nxt < V_VS_END);
            cmos_href   <= nxt_active;
            if (pix_ready) begin
                cmos_d    <= fetch_word[15:8];
                pix_lo    <= fetch_word[7:0];
                underflow <= !pix_valid;
            end else begin
                cmos_d    <= nxt_active ? pix_lo : 8'h00;
                underflow <= 1'b0;
            end
        end
    end

endmodule
